// File: rtl/pmu_pkg.sv
// ---------------------------------------------------------------------------
// Module : pmu_pkg
// Brief  : Shared constants and FSM state type for the PMU collector.
// Rev    : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

package pmu_pkg;

  localparam int          PMU_NUM_CNTRS = 19;
  localparam int          PMU_ADDR_W    = 5;
  localparam logic [15:0] PMU_HDR_MAGIC = 16'h504D;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEL  = 2'd1,
    CAPT = 2'd2,
    SEND = 2'd3
  } pmu_coll_state_e;

endpackage

`default_nettype wire

// File: rtl/pmu_period_timer.sv
// ---------------------------------------------------------------------------
// Module : pmu_period_timer
// Brief  : Free-running interval timer; one-cycle hit every period_i cycles.
// Rev    : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module pmu_period_timer #(
  parameter int PERIOD_W = 32
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic [PERIOD_W-1:0] period_i,
  output logic                hit_o
);

  logic [PERIOD_W-1:0] count_q, count_d;

  // A zero period parks the counter so a later non-zero value starts cleanly.
  always_comb begin
    hit_o   = 1'b0;
    count_d = count_q + PERIOD_W'(1);
    if (period_i == '0) begin
      count_d = '0;
    end else if (count_q == period_i - PERIOD_W'(1)) begin
      hit_o   = 1'b1;
      count_d = '0;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/pmu_collector.sv
// ---------------------------------------------------------------------------
// Module : pmu_collector
// Brief  : Reads every counter of NUM_PMUS PMUs and streams them as one
//          AXI-Stream frame. Optional header beat: PMU_COLLECTOR_HEADER_EN.
// Rev    : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module pmu_collector
  import pmu_pkg::*;
#(
  parameter int NUM_PMUS = 4,
  parameter int PERIOD_W = 32,
  parameter int OVF_W    = 16
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   start_i,
  input  logic [PERIOD_W-1:0]    period_i,
  output logic [PMU_ADDR_W-1:0]  pmu_addr_o,
  input  logic [NUM_PMUS*64-1:0] pmu_data_i,
  output logic                   m_tvalid,
  input  logic                   m_tready,
  output logic [63:0]            m_tdata,
  output logic                   m_tlast,
  output logic                   busy_o,
  output logic [OVF_W-1:0]       overrun_o
);

  localparam int PIDX_W = (NUM_PMUS > 1) ? $clog2(NUM_PMUS) : 1;

  pmu_coll_state_e       state_q, state_d;
  logic [PIDX_W-1:0]     pmu_idx_q, pmu_idx_d;
  logic [PMU_ADDR_W-1:0] cnt_idx_q, cnt_idx_d;
  logic [PMU_ADDR_W-1:0] addr_q, addr_d;
  logic [63:0]           data_q, data_d;
  logic [OVF_W-1:0]      ovf_q, ovf_d;
  logic [31:0]           seq_q, seq_d;
  logic                  hdr_q, hdr_d;

  logic w_timer_hit;
  logic w_trig;
  logic w_last;

  pmu_period_timer #(
    .PERIOD_W (PERIOD_W)
  ) u_timer (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .period_i (period_i),
    .hit_o    (w_timer_hit)
  );

  assign w_trig = start_i | w_timer_hit;
  assign w_last = !hdr_q
                  && (pmu_idx_q == PIDX_W'(NUM_PMUS - 1))
                  && (cnt_idx_q == PMU_ADDR_W'(PMU_NUM_CNTRS - 1));

  always_comb begin
    state_d   = state_q;
    pmu_idx_d = pmu_idx_q;
    cnt_idx_d = cnt_idx_q;
    addr_d    = addr_q;
    data_d    = data_q;
    ovf_d     = ovf_q;
    seq_d     = seq_q;
    hdr_d     = hdr_q;

    // Triggers arriving mid-frame are dropped, only counted.
    if (w_trig && (state_q != IDLE) && (ovf_q != '1)) begin
      ovf_d = ovf_q + OVF_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (w_trig) begin
          pmu_idx_d = '0;
          cnt_idx_d = '0;
`ifdef PMU_COLLECTOR_HEADER_EN
          data_d  = {PMU_HDR_MAGIC, 8'(NUM_PMUS), 8'(PMU_NUM_CNTRS), seq_q};
          hdr_d   = 1'b1;
          state_d = SEND;
`else
          state_d = SEL;
`endif
        end
      end
      SEL: begin
        addr_d  = cnt_idx_q;
        state_d = CAPT;
      end
      CAPT: begin
        data_d  = pmu_data_i[64*int'(pmu_idx_q) +: 64];
        state_d = SEND;
      end
      SEND: begin
        if (m_tready) begin
          if (hdr_q) begin
            hdr_d   = 1'b0;
            state_d = SEL;
          end else if (w_last) begin
            seq_d   = seq_q + 32'd1;
            state_d = IDLE;
          end else begin
            state_d = SEL;
            if (cnt_idx_q == PMU_ADDR_W'(PMU_NUM_CNTRS - 1)) begin
              cnt_idx_d = '0;
              pmu_idx_d = pmu_idx_q + PIDX_W'(1);
            end else begin
              cnt_idx_d = cnt_idx_q + PMU_ADDR_W'(1);
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= IDLE;
      pmu_idx_q <= '0;
      cnt_idx_q <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      ovf_q     <= '0;
      seq_q     <= '0;
      hdr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pmu_idx_q <= pmu_idx_d;
      cnt_idx_q <= cnt_idx_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      ovf_q     <= ovf_d;
      seq_q     <= seq_d;
      hdr_q     <= hdr_d;
    end
  end

  assign pmu_addr_o = addr_q;
  assign m_tvalid   = (state_q == SEND);
  assign m_tdata    = data_q;
  assign m_tlast    = (state_q == SEND) && w_last;
  assign busy_o     = (state_q != IDLE);
  assign overrun_o  = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_pmu_collector.sv
// ---------------------------------------------------------------------------
// Module : tb_pmu_collector
// Brief  : Scoreboard bench for pmu_collector with a frame-level reference
//          model. Honours PMU_COLLECTOR_HEADER_EN.
// Rev    : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_pmu_collector;
  import pmu_pkg::*;

  localparam int NP = 2;
  localparam int NC = PMU_NUM_CNTRS;
`ifdef PMU_COLLECTOR_HEADER_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif
  localparam int NB        = NP * NC;
  localparam int FRAME_CYC = 3 * NB + HDR;
  localparam int OVF_MAX   = 65535;
  localparam int OVF2_MAX  = 3;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          start_i = 1'b0;
  logic          m_tready = 1'b1;
  logic [31:0]   period_i = '0;
  logic [4:0]    pmu_addr, d2_addr;
  logic [NP*64-1:0] pmu_data, pmu_data2;
  logic          m_tvalid, m_tlast, busy_o;
  logic [63:0]   m_tdata;
  logic [15:0]   overrun_o;
  logic          d2_tvalid, d2_tlast, d2_busy;
  logic [63:0]   d2_tdata;
  logic [1:0]    d2_ovf;

  always #5 aclk = ~aclk;

  pmu_collector #(.NUM_PMUS(NP), .PERIOD_W(32), .OVF_W(16)) dut (
    .aclk(aclk), .aresetn(aresetn), .start_i(start_i), .period_i(period_i),
    .pmu_addr_o(pmu_addr), .pmu_data_i(pmu_data), .m_tvalid(m_tvalid),
    .m_tready(m_tready), .m_tdata(m_tdata), .m_tlast(m_tlast),
    .busy_o(busy_o), .overrun_o(overrun_o)
  );

  // Narrow overrun counter variant, driven identically.
  pmu_collector #(.NUM_PMUS(NP), .PERIOD_W(32), .OVF_W(2)) dut2 (
    .aclk(aclk), .aresetn(aresetn), .start_i(start_i), .period_i(period_i),
    .pmu_addr_o(d2_addr), .pmu_data_i(pmu_data2), .m_tvalid(d2_tvalid),
    .m_tready(m_tready), .m_tdata(d2_tdata), .m_tlast(d2_tlast),
    .busy_o(d2_busy), .overrun_o(d2_ovf)
  );

  // PMU p counter k reads as {salt ^ p, k}; salt changes only between frames.
  logic [31:0] salt = '0;
  always_comb begin
    pmu_data  = '0;
    pmu_data2 = '0;
    for (int p = 0; p < NP; p++) begin
      pmu_data[64*p +: 64]  = {salt ^ 32'(p), 27'd0, pmu_addr};
      pmu_data2[64*p +: 64] = {salt ^ 32'(p), 27'd0, d2_addr};
    end
  end

  typedef struct {
    logic [63:0] data;
    logic        last;
    logic        first;
    int          due;
  } beat_t;

  beat_t       sb[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          p_base = 0;
  int          mbusy = 0;
  int          exp_ovf = 0;
  int          beats_seen = 0;
  logic [31:0] mseq = '0;
  logic        rand_rdy = 1'b0;
  logic        first_frame = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic void push_frame(input int t);
    beat_t b;
    salt = first_frame ? 32'd0 : $urandom;
    if (HDR != 0) begin
      b.data  = {PMU_HDR_MAGIC, 8'(NP), 8'(NC), mseq};
      b.last  = 1'b0;
      b.first = 1'b1;
      b.due   = t + 1;
      sb.push_back(b);
    end
    for (int p = 0; p < NP; p++) begin
      for (int k = 0; k < NC; k++) begin
        b.data  = {salt ^ 32'(p), 32'(k)};
        b.last  = (p == NP - 1) && (k == NC - 1);
        b.first = (HDR == 0) && (p == 0) && (k == 0);
        b.due   = t + 3;
        sb.push_back(b);
      end
    end
    mseq = mseq + 32'd1;
  endfunction

  // One clock cycle of stimulus plus the frame-level trigger model.
  task automatic cycle(input logic st);
    logic hit;
    start_i  = st;
    m_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    hit = (period_i != 0) &&
          (((cyc - p_base) % int'(period_i)) == int'(period_i) - 1);
    if (st || hit) begin
      if (mbusy > 0) begin
        if (exp_ovf < OVF_MAX) exp_ovf++;
      end else begin
        push_frame(cyc);
        mbusy = rand_rdy ? (1 << 30) : FRAME_CYC + 1;
      end
    end
    @(posedge aclk);
    #1;
    cyc++;
    if (mbusy > 0) mbusy--;
    start_i = 1'b0;
  endtask

  task automatic set_period(input int p);
    period_i = 32'(p);
    p_base   = cyc;
  endtask

  task automatic wait_idle(input int maxc);
    int n;
    n = 0;
    while ((busy_o || sb.size() != 0) && n < maxc) begin
      cycle(1'b0);
      n++;
    end
    total++;
    if (busy_o || sb.size() != 0) begin
      bad++;
      $display("FAIL idle_timeout: busy=%0d pending=%0d, required 0 and 0", busy_o, sb.size());
    end
    mbusy = 0;
  endtask

  // Monitor: pops the scoreboard on every handshake, checks hold-while-stalled.
  logic        pv = 1'b0, pr = 1'b0, pl = 1'b0, busy_chk = 1'b0;
  logic [63:0] pd = '0;
  int          pres = 0;
  beat_t       mb;

  always @(negedge aclk) begin
    if (!aresetn) begin
      pv       = 1'b0;
      busy_chk = 1'b0;
    end else begin
      if (busy_chk) begin
        chk("busy_after_last", 64'(busy_o), 64'd0);
        busy_chk = 1'b0;
      end
      if (pv && !pr) begin
        chk("hold_valid", 64'(m_tvalid), 64'd1);
        chk("hold_data", m_tdata, pd);
        chk("hold_last", 64'(m_tlast), 64'(pl));
      end
      if (m_tvalid && !(pv && !pr)) pres = cyc;
      if (m_tvalid && m_tready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_beat: got %h, required no beat", m_tdata);
        end else begin
          mb = sb.pop_front();
          chk("tdata", m_tdata, mb.data);
          chk("tlast", 64'(m_tlast), 64'(mb.last));
          chk("d2_tdata", d2_tdata, mb.data);
          chk("d2_tlast", 64'(d2_tlast), 64'(mb.last));
          if (mb.first) chk("first_beat_cycle", 64'(pres), 64'(mb.due));
          if (mb.last) busy_chk = 1'b1;
        end
        beats_seen++;
      end
      pv = m_tvalid;
      pr = m_tready;
      pd = m_tdata;
      pl = m_tlast;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1);
  end

  initial begin
    int base;
    int n;

    repeat (3) cycle(1'b0);
    chk("rst_tvalid", 64'(m_tvalid), 64'd0);
    chk("rst_tlast", 64'(m_tlast), 64'd0);
    chk("rst_tdata", m_tdata, 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_addr", 64'(pmu_addr), 64'd0);
    chk("rst_overrun", 64'(overrun_o), 64'd0);
    aresetn = 1'b1;
    cycle(1'b0);

    // Single software-triggered frame, no backpressure, known counter values.
    first_frame = 1'b1;
    cycle(1'b1);
    first_frame = 1'b0;
    wait_idle(400);

    // Five extra pulses while busy.
    cycle(1'b1);
    repeat (5) begin
      cycle(1'b0);
      cycle(1'b1);
    end
    wait_idle(400);
    chk("overrun_5", 64'(overrun_o), 64'(exp_ovf));
    chk("overrun_sat2", 64'(d2_ovf), 64'((exp_ovf > OVF2_MAX) ? OVF2_MAX : exp_ovf));

    // Random backpressure with a few dropped pulses near frame start.
    rand_rdy = 1'b1;
    repeat (3) begin
      cycle(1'b1);
      for (int i = 0; i < 8; i++) cycle($urandom_range(0, 3) == 0);
      wait_idle(4000);
    end
    rand_rdy = 1'b0;
    chk("overrun_rand", 64'(overrun_o), 64'(exp_ovf));

    // Periodic trigger, frames fit inside the interval.
    set_period(200);
    repeat (700) cycle(1'b0);
    set_period(0);
    wait_idle(400);
    chk("overrun_p200", 64'(overrun_o), 64'(exp_ovf));

    // Interval shorter than a frame: hits fall on busy cycles.
    set_period(50);
    repeat (500) cycle(1'b0);
    set_period(0);
    wait_idle(400);
    chk("overrun_p50", 64'(overrun_o), 64'(exp_ovf));
    chk("overrun_p50_sat2", 64'(d2_ovf), 64'((exp_ovf > OVF2_MAX) ? OVF2_MAX : exp_ovf));

    // Reset in the middle of a frame while a beat is presented.
    base = beats_seen;
    cycle(1'b1);
    n = 0;
    while (!(beats_seen >= base + 10 && m_tvalid) && n < 500) begin
      cycle(1'b0);
      n++;
    end
    chk("reached_beat10", 64'(beats_seen >= base + 10 && m_tvalid), 64'd1);
    #2;
    aresetn = 1'b0;
    #1;
    chk("arst_tvalid", 64'(m_tvalid), 64'd0);
    chk("arst_tlast", 64'(m_tlast), 64'd0);
    chk("arst_tdata", m_tdata, 64'd0);
    chk("arst_busy", 64'(busy_o), 64'd0);
    chk("arst_overrun", 64'(overrun_o), 64'd0);
    sb.delete();
    mbusy   = 0;
    exp_ovf = 0;
    mseq    = '0;
    cycle(1'b0);
    cycle(1'b0);
    aresetn = 1'b1;
    cycle(1'b0);
    cycle(1'b1);
    wait_idle(400);
    chk("post_rst_overrun", 64'(overrun_o), 64'd0);

    // Two back-to-back frames (header sequence numbers 0 and 1 when enabled).
    cycle(1'b1);
    wait_idle(400);
    chk("final_overrun", 64'(overrun_o), 64'(exp_ovf));
    chk("final_sb_empty", 64'(sb.size()), 64'd0);
    chk("final_d2_busy", 64'(d2_busy), 64'd0);
    chk("final_d2_tvalid", 64'(d2_tvalid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
